pingpong_bank_scheduler: RTL and testbench
==========================================

# pingpong_bank_scheduler

- Schedules the two interleaver RAM banks as a ping-pong pair.
- A CRC-side writer fills one bank with a block (K = 1056 or 6144) while an encoder-side reader drains the other; the two sides run concurrently on different banks.
- Tracks per-bank ownership, generates write and read addresses, and applies start/ready handshakes on both sides.
- Sits between the CRC attachment stage and the dual-bank interleaver RAM; replaces fixed-sequence bank control.

## Interface
Parameters:
- ADDR_W, 13, address/counter width (must hold K_LARGE-1)
- K_SMALL, 1056, block length when blk=0
- K_LARGE, 6144, block length when blk=1

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- in_start  in  1  writer requests a bank; held high until in_start_ack
- in_blk  in  1  block size of requested block; sampled on ack cycle
- in_start_ack  out  1  one-cycle pulse; bank granted
- in_valid  in  1  write beat
- in_ready  out  1  writer owns a filling bank
- ram_we  out  2  per-bank write enable, = in_valid & in_ready on the filling bank
- ram_waddr  out  ADDR_W  write address
- out_ready  in  1  downstream read request
- ram_rd_en  out  1  read strobe
- ram_rsel  out  1  bank being read
- ram_raddr  out  ADDR_W  read address
- out_valid  out  1  ram_rd_en delayed one cycle (RAM read data valid)
- out_blk  out  1  size of the block being drained
- out_last  out  1  with out_valid, final word of block
- done  out  1  one-cycle pulse after final word of a block is valid
- bank_state  out  4  {bank1, bank0} 2-bit states, for debug

## Operation
- Per-bank state:
  - EMPTY=0
  - FILL=1
  - FULL=2
  - DRAIN=3
  - Each bank also holds a stored blk bit.
- Bank pointers: wr_ptr and rd_ptr, 1 bit each, both reset to 0.
  - wr_ptr toggles when a fill completes; rd_ptr toggles when a drain completes.
  - This keeps strict block order.
- Grant:
  - Condition: in_start, writer idle, bank[wr_ptr]==EMPTY.
  - Registered result: in_start_ack=1, bank -> FILL, stored blk <= in_blk, wcount <= 0.
- Fill:
  - Each beat with in_valid & in_ready writes ram_waddr=wcount and increments wcount.
  - On the beat with wcount==K-1: bank -> FULL, in_ready falls next cycle, wr_ptr toggles.
- Drain start: writer-independent. When reader is idle and bank[rd_ptr]==FULL: bank -> DRAIN, rcount <= 0.
- Read:
  - ram_rd_en = DRAIN & out_ready; ram_raddr=rcount; rcount increments per rd_en.
  - On rd_en with rcount==K-1: bank -> EMPTY, rd_ptr toggles.
  - out_last and done follow one cycle later with out_valid.
- Downstream must accept every out_valid; out_ready is a request, not backpressure on returned data.
- in_valid while in_ready=0: ignored, no ram_we.
- in_start while no bank is EMPTY: no ack; request is held until a bank frees.
- Reset:
  - All outputs 0.
  - Both banks EMPTY, pointers 0, counters 0.
  - Mid-operation reset discards partial blocks.

## Timing
- Grant:
  - in_start_ack is asserted the cycle after in_start is sampled with the bank free.
  - in_ready is high from the cycle after ack.
- Write: zero latency; ram_we and ram_waddr are combinational from in_valid and registered wcount.
- Fill-to-drain: bank FULL at edge N; drain may begin at edge N+1; first ram_rd_en at earliest cycle N+1.
- Drain-to-refill: bank EMPTY at edge M; a grant on that bank is possible at edge M+1.
- Read: one-cycle read latency; out_valid, out_last and done are registered.
- Simultaneous events: a last write on one bank and a last read on the other in the same cycle both take effect at that edge.
- Throughput: one write beat and one read beat per cycle, concurrent.

## Structure
- Shared package interleaver_pkg holds:
  - bank state encoding (EMPTY/FILL/FULL/DRAIN)
  - K_SMALL/K_LARGE constants
  - ADDR_W
- Sub-module blk_addr_counter, instanced twice (write side and read side):
  - inputs: clr, en, blk
  - outputs: count[ADDR_W-1:0], last (count==K(blk)-1)
  - synchronous clr, async reset
- Bank state machines and pointers are flat in the top module.

## Test plan
- Single small block:
  - Stimulus: in_start, blk=0, 1056 beats.
  - Expected: ack once; ram_we[0] on addr 0..1055; 1056 reads of bank0 addr 0..1055 with out_ready=1; out_last on the 1056th out_valid; done once.
- Three large blocks back-to-back:
  - Grants go to banks 0, 1, 0.
  - The third ack is withheld until bank0 reaches EMPTY, then comes 1 cycle later.
- Read backpressure:
  - Stimulus: out_ready toggled every cycle on a 6144 block.
  - Expected: ram_raddr advances only on out_ready cycles; exactly 6144 out_valid; done after the last.
- Simultaneous completion:
  - Stimulus: last write of bank1 and last read of bank0 in the same cycle.
  - Expected: next cycle bank_state = {FULL, EMPTY}; a pending in_start is acked to bank0.
- Reset mid-fill:
  - Stimulus: assert reset at write beat 500.
  - Expected: all outputs 0 immediately; next block is granted bank0 with waddr starting at 0.
- Illegal beats:
  - Stimulus: in_valid pulses before ack and after the last beat.
  - Expected: ram_we stays 0 and wcount is unchanged.

Source files
------------

// File: rtl/interleaver_pkg.sv
// Shared definitions for the ping-pong interleaver bank scheduler: bank
// state encoding, block lengths and address width.
package interleaver_pkg;
   localparam int ADDR_W  = 13;
   localparam int K_SMALL = 1056;
   localparam int K_LARGE = 6144;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FILL  = 2'd1,
      FULL  = 2'd2,
      DRAIN = 2'd3
   } bank_state_e;
endpackage

// File: rtl/blk_addr_counter.sv
// Block address counter: counts beats within a block and flags the final
// address for the selected block length.
module blk_addr_counter #(
   parameter int ADDR_W  = interleaver_pkg::ADDR_W,
   parameter int K_SMALL = interleaver_pkg::K_SMALL,
   parameter int K_LARGE = interleaver_pkg::K_LARGE
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clr,
   input  logic              en,
   input  logic              blk,
   output logic [ADDR_W-1:0] count,
   output logic              last
);
   logic [ADDR_W-1:0] count_max;

   assign count_max = blk ? ADDR_W'(K_LARGE - 1) : ADDR_W'(K_SMALL - 1);
   assign last      = (count == count_max);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)    count <= '0;
      else if (clr) count <= '0;
      else if (en)  count <= count + ADDR_W'(1);
   end
endmodule

// File: rtl/pingpong_bank_scheduler.sv
// Ping-pong scheduler for the two interleaver RAM banks: the writer fills
// bank[wr_ptr] while the reader drains bank[rd_ptr], strictly in block order.
module pingpong_bank_scheduler #(
   parameter int ADDR_W  = interleaver_pkg::ADDR_W,
   parameter int K_SMALL = interleaver_pkg::K_SMALL,
   parameter int K_LARGE = interleaver_pkg::K_LARGE
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_start,
   input  logic              in_blk,
   output logic              in_start_ack,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [1:0]        ram_we,
   output logic [ADDR_W-1:0] ram_waddr,
   input  logic              out_ready,
   output logic              ram_rd_en,
   output logic              ram_rsel,
   output logic [ADDR_W-1:0] ram_raddr,
   output logic              out_valid,
   output logic              out_blk,
   output logic              out_last,
   output logic              done,
   output logic [3:0]        bank_state
);
   import interleaver_pkg::*;

   bank_state_e       bank_q [2];
   bank_state_e       bank_d [2];
   logic [1:0]        blk_q, blk_d;
   logic              wr_ptr, rd_ptr;
   logic [ADDR_W-1:0] wcount, rcount;
   logic              wlast, rlast;
   logic              grant, wr_beat, wr_done, drain_start, rd_done;

   // Grant needs the bank at wr_ptr to be EMPTY, which also implies the
   // writer is not mid-fill (that bank would be FILL).
   assign grant       = in_start && (bank_q[wr_ptr] == EMPTY);
   assign wr_beat     = in_valid && in_ready;
   assign wr_done     = wr_beat && wlast;
   assign drain_start = (bank_q[rd_ptr] == FULL);
   assign ram_rd_en   = (bank_q[rd_ptr] == DRAIN) && out_ready;
   assign rd_done     = ram_rd_en && rlast;

   assign ram_we     = wr_beat ? (wr_ptr ? 2'b10 : 2'b01) : 2'b00;
   assign ram_waddr  = wcount;
   assign ram_rsel   = rd_ptr;
   assign ram_raddr  = rcount;
   assign bank_state = {bank_q[1], bank_q[0]};

   blk_addr_counter #(.ADDR_W(ADDR_W), .K_SMALL(K_SMALL), .K_LARGE(K_LARGE)) u_wr_cnt (
      .clk(clk), .reset(reset), .clr(grant), .en(wr_beat), .blk(blk_q[wr_ptr]),
      .count(wcount), .last(wlast)
   );

   blk_addr_counter #(.ADDR_W(ADDR_W), .K_SMALL(K_SMALL), .K_LARGE(K_LARGE)) u_rd_cnt (
      .clk(clk), .reset(reset), .clr(drain_start), .en(ram_rd_en), .blk(blk_q[rd_ptr]),
      .count(rcount), .last(rlast)
   );

   // Writer and reader events always hit different banks or mutually
   // exclusive states, so the updates below never collide.
   always_comb begin
      bank_d = bank_q;
      blk_d  = blk_q;
      if (grant) begin
         bank_d[wr_ptr] = FILL;
         blk_d[wr_ptr]  = in_blk;
      end
      if (wr_done)     bank_d[wr_ptr] = FULL;
      if (drain_start) bank_d[rd_ptr] = DRAIN;
      if (rd_done)     bank_d[rd_ptr] = EMPTY;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bank_q[0] <= EMPTY;
         bank_q[1] <= EMPTY;
         blk_q     <= '0;
         wr_ptr    <= 1'b0;
         rd_ptr    <= 1'b0;
      end else begin
         bank_q <= bank_d;
         blk_q  <= blk_d;
         wr_ptr <= wr_ptr ^ wr_done;
         rd_ptr <= rd_ptr ^ rd_done;
      end
   end

   // Handshake and read-return registers; out_* track the RAM's one-cycle latency.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         in_start_ack <= 1'b0;
         in_ready     <= 1'b0;
         out_valid    <= 1'b0;
         out_blk      <= 1'b0;
         out_last     <= 1'b0;
         done         <= 1'b0;
      end else begin
         in_start_ack <= grant;
         if (wr_done)           in_ready <= 1'b0;
         else if (in_start_ack) in_ready <= 1'b1;
         out_valid <= ram_rd_en;
         if (ram_rd_en) out_blk <= blk_q[rd_ptr];
         out_last  <= rd_done;
         done      <= rd_done;
      end
   end
endmodule

// File: tb/tb_pingpong_bank_scheduler.sv
// Self-checking bench for pingpong_bank_scheduler: randomized writer/reader
// traffic checked against a block-order queue model.
module tb_pingpong_bank_scheduler;
   localparam int AW = 13;
   localparam int KS = 1056;
   localparam int KL = 6144;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          in_start = 1'b0, in_blk = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic          in_start_ack, in_ready, ram_rd_en, ram_rsel, out_valid, out_blk, out_last, done;
   logic [1:0]    ram_we;
   logic [AW-1:0] ram_waddr, ram_raddr;
   logic [3:0]    bank_state;

   int n_cmp = 0, n_bad = 0, cyc = 0;

   // Model: completed blocks awaiting drain, in order; writer's expected bank.
   typedef struct { logic bank; logic blk; } blk_t;
   blk_t exp_q[$];
   logic wr_bank = 1'b0;

   pingpong_bank_scheduler dut (
      .clk(clk), .reset(reset), .in_start(in_start), .in_blk(in_blk),
      .in_start_ack(in_start_ack), .in_valid(in_valid), .in_ready(in_ready),
      .ram_we(ram_we), .ram_waddr(ram_waddr), .out_ready(out_ready),
      .ram_rd_en(ram_rd_en), .ram_rsel(ram_rsel), .ram_raddr(ram_raddr),
      .out_valid(out_valid), .out_blk(out_blk), .out_last(out_last),
      .done(done), .bank_state(bank_state)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; in_start = 1'b0; in_blk = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      exp_q.delete();
      wr_bank = 1'b0;
   endtask

   // Writer: request a bank, stream K beats, then probe an illegal beat.
   task automatic write_block(input logic blk, input int vprob, output int waited);
      int k, i, first_empty, guard;
      logic [1:0] exp_we;
      bit acked;
      k = blk ? KL : KS; i = 0; first_empty = -1; waited = 0; acked = 0; guard = 0;
      exp_we = wr_bank ? 2'b10 : 2'b01;
      @(negedge clk); in_start = 1'b1; in_blk = blk;
      while (!acked && waited < 40000) begin
         in_valid = ($urandom_range(0, 99) < 50);
         #1;
         n_cmp++; if (ram_we !== 2'b00) begin n_bad++; $display("FAIL pre_ack_we: got %b want 00", ram_we); end
         if (in_start_ack === 1'b1) begin
            acked = 1; in_start = 1'b0;
            n_cmp++; if (cyc !== first_empty + 1) begin n_bad++; $display("FAIL ack_latency: ack cycle %0d, bank empty seen at %0d", cyc, first_empty); end
            n_cmp++; if (bank_state[2*wr_bank +: 2] !== 2'd1) begin n_bad++; $display("FAIL grant_bank: bank_state %b, bank %0d not FILL", bank_state, wr_bank); end
            n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL ready_at_ack: got %b want 0", in_ready); end
         end else begin
            if (first_empty < 0 && bank_state[2*wr_bank +: 2] === 2'd0) first_empty = cyc;
            waited++;
            @(negedge clk);
         end
      end
      n_cmp++;
      if (!acked) begin
         n_bad++; $display("FAIL ack_timeout: no in_start_ack after %0d cycles", waited);
         in_start = 1'b0; in_valid = 1'b0;
         return;
      end
      while (i < k && guard < 100000) begin
         @(negedge clk);
         in_valid = ($urandom_range(0, 99) < vprob);
         #1; guard++;
         if (guard == 1) begin
            n_cmp++; if (in_start_ack !== 1'b0) begin n_bad++; $display("FAIL ack_pulse: ack still %b", in_start_ack); end
         end
         n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL in_ready_fill: got %b want 1 at beat %0d", in_ready, i); end
         if (in_valid) begin
            n_cmp++;
            if (ram_we !== exp_we || ram_waddr !== i[AW-1:0]) begin
               n_bad++; $display("FAIL wr_beat: we=%b addr=%0d want we=%b addr=%0d", ram_we, ram_waddr, exp_we, i);
            end
            i++;
         end else begin
            n_cmp++; if (ram_we !== 2'b00) begin n_bad++; $display("FAIL idle_we: got %b want 00", ram_we); end
         end
      end
      n_cmp++; if (i != k) begin n_bad++; $display("FAIL fill_timeout: %0d of %0d beats", i, k); end
      exp_q.push_back('{bank: wr_bank, blk: blk});
      wr_bank = ~wr_bank;
      @(negedge clk); in_valid = 1'b1; #1;
      n_cmp++; if (in_ready !== 1'b0 || ram_we !== 2'b00) begin n_bad++; $display("FAIL post_last_beat: in_ready=%b we=%b want 0/00", in_ready, ram_we); end
      in_valid = 1'b0;
   endtask

   // Reader: drive out_ready and check every read strobe and returned word.
   task automatic read_blocks(input int n, input int rprob, input bit alt, input int exp_words);
      int done_blk, ridx, nval, ndone, guard, k;
      logic prv_rd, prv_last, prv_blk;
      bit fin;
      blk_t h;
      done_blk = 0; ridx = 0; nval = 0; ndone = 0; guard = 0; fin = 0;
      prv_rd = 1'b0; prv_last = 1'b0; prv_blk = 1'b0;
      while (!fin && guard < 60000) begin
         @(negedge clk);
         if (alt) out_ready = ~out_ready;
         else     out_ready = ($urandom_range(0, 99) < rprob);
         #1; guard++;
         n_cmp++;
         if (out_valid !== prv_rd || out_last !== prv_last || done !== prv_last) begin
            n_bad++; $display("FAIL read_return: valid/last/done=%b%b%b want %b%b%b", out_valid, out_last, done, prv_rd, prv_last, prv_last);
         end
         if (prv_rd) begin
            n_cmp++; if (out_blk !== prv_blk) begin n_bad++; $display("FAIL out_blk: got %b want %b", out_blk, prv_blk); end
         end
         if (out_valid === 1'b1) nval++;
         if (done === 1'b1) ndone++;
         if (done_blk == n) fin = 1;
         prv_rd = 1'b0; prv_last = 1'b0;
         if (ram_rd_en === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0 || out_ready !== 1'b1) begin
               n_bad++; $display("FAIL rd_unexpected: rd_en with %0d blocks ready, out_ready=%b", exp_q.size(), out_ready);
            end else begin
               h = exp_q[0];
               k = h.blk ? KL : KS;
               if (ram_rsel !== h.bank || ram_raddr !== ridx[AW-1:0]) begin
                  n_bad++; $display("FAIL rd_addr: bank=%b addr=%0d want bank=%b addr=%0d", ram_rsel, ram_raddr, h.bank, ridx);
               end
               prv_rd = 1'b1; prv_blk = h.blk; prv_last = (ridx == k - 1);
               ridx++;
               if (prv_last) begin void'(exp_q.pop_front()); ridx = 0; done_blk++; end
            end
         end
      end
      out_ready = 1'b0;
      n_cmp++; if (!fin) begin n_bad++; $display("FAIL read_timeout: %0d of %0d blocks drained", done_blk, n); end
      n_cmp++; if (nval != exp_words) begin n_bad++; $display("FAIL out_valid_count: got %0d want %0d", nval, exp_words); end
      n_cmp++; if (ndone != n) begin n_bad++; $display("FAIL done_count: got %0d want %0d", ndone, n); end
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b1; in_start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      n_cmp++;
      if ({in_start_ack, in_ready, ram_we, ram_waddr, ram_rd_en, ram_rsel, ram_raddr,
           out_valid, out_blk, out_last, done, bank_state} !== 40'd0) begin
         n_bad++; $display("FAIL reset_outputs: bank_state=%b we=%b rd_en=%b not all zero", bank_state, ram_we, ram_rd_en);
      end
      do_reset();
      #1;
      n_cmp++;
      if ({in_start_ack, in_ready, ram_we, ram_waddr, ram_rd_en, ram_rsel, ram_raddr,
           out_valid, out_blk, out_last, done, bank_state} !== 40'd0) begin
         n_bad++; $display("FAIL post_reset_idle: bank_state=%b in_ready=%b not all zero", bank_state, in_ready);
      end
   endtask

   task automatic test_single_small();
      int w;
      do_reset();
      fork
         write_block(1'b0, 70, w);
         read_blocks(1, 100, 1'b0, KS);
      join
   endtask

   task automatic test_back_to_back();
      int w1, w2, w3;
      do_reset();
      fork
         begin
            write_block(1'b1, 100, w1);
            write_block(1'b1, 100, w2);
            write_block(1'b1, 100, w3);
            n_cmp++; if (w3 < 5) begin n_bad++; $display("FAIL third_ack_withheld: waited %0d cycles, want >= 5", w3); end
         end
         read_blocks(3, 75, 1'b0, 3 * KL);
      join
   endtask

   task automatic test_backpressure();
      int w;
      do_reset();
      fork
         write_block(1'b1, 100, w);
         read_blocks(1, 0, 1'b1, KL);
      join
   endtask

   task automatic test_simultaneous();
      int w, guard;
      do_reset();
      write_block(1'b0, 100, w);
      @(negedge clk); in_start = 1'b1; in_blk = 1'b0; guard = 0;
      #1;
      while (in_start_ack !== 1'b1 && guard < 20) begin @(negedge clk); #1; guard++; end
      n_cmp++;
      if (in_start_ack !== 1'b1 || bank_state !== 4'b0111) begin
         n_bad++; $display("FAIL sim_grant: ack=%b bank_state=%b want 1/0111", in_start_ack, bank_state);
      end
      for (int i = 0; i < KS; i++) begin
         @(negedge clk); in_valid = 1'b1; out_ready = 1'b1; #1;
         n_cmp++;
         if (ram_we !== 2'b10 || ram_waddr !== AW'(i) || ram_rd_en !== 1'b1 ||
             ram_rsel !== 1'b0 || ram_raddr !== AW'(i)) begin
            n_bad++; $display("FAIL lockstep: we=%b wa=%0d rd=%b rs=%b ra=%0d want 10/%0d/1/0/%0d",
                              ram_we, ram_waddr, ram_rd_en, ram_rsel, ram_raddr, i, i);
         end
      end
      @(negedge clk); in_valid = 1'b0; out_ready = 1'b0; #1;
      n_cmp++;
      if (bank_state !== 4'b1000 || in_start_ack !== 1'b0 || in_ready !== 1'b0 ||
          {out_valid, out_last, done} !== 3'b111) begin
         n_bad++; $display("FAIL sim_complete: bank_state=%b ack=%b rdy=%b v/l/d=%b%b%b want 1000/0/0/111",
                           bank_state, in_start_ack, in_ready, out_valid, out_last, done);
      end
      @(negedge clk); #1;
      n_cmp++;
      if (in_start_ack !== 1'b1 || bank_state[1:0] !== 2'd1) begin
         n_bad++; $display("FAIL sim_regrant: ack=%b bank_state=%b want ack=1 bank0 FILL", in_start_ack, bank_state);
      end
      in_start = 1'b0;
   endtask

   task automatic test_reset_mid_fill();
      int beats, guard, w;
      do_reset();
      beats = 0; guard = 0;
      @(negedge clk); in_start = 1'b1; in_blk = 1'b1;
      do begin @(negedge clk); #1; guard++; end while (in_start_ack !== 1'b1 && guard < 20);
      in_start = 1'b0;
      while (beats < 500 && guard < 2000) begin
         @(negedge clk); in_valid = 1'b1; #1; guard++;
         if (ram_we === 2'b01) beats++;
      end
      @(negedge clk); out_ready = 1'b1; #1;
      n_cmp++; if (ram_waddr !== AW'(500)) begin n_bad++; $display("FAIL mid_fill_addr: got %0d want 500", ram_waddr); end
      reset = 1'b1; #1;
      n_cmp++;
      if ({in_start_ack, in_ready, ram_we, ram_waddr, ram_rd_en, ram_rsel, ram_raddr,
           out_valid, out_blk, out_last, done, bank_state} !== 40'd0) begin
         n_bad++; $display("FAIL reset_mid_fill: we=%b waddr=%0d bank_state=%b not all zero", ram_we, ram_waddr, bank_state);
      end
      do_reset();
      fork
         write_block(1'b0, 100, w);
         read_blocks(1, 100, 1'b0, KS);
      join
   endtask

   task automatic test_illegal_beats();
      int w;
      logic b0, b1;
      do_reset();
      b0 = ($urandom_range(0, 3) == 0);
      b1 = ($urandom_range(0, 3) == 0);
      fork
         begin
            write_block(b0, 60, w);
            write_block(b1, 60, w);
         end
         read_blocks(2, 70, 1'b0, (b0 ? KL : KS) + (b1 ? KL : KS));
      join
   endtask

   initial begin
      test_reset();
      test_single_small();
      test_back_to_back();
      test_backpressure();
      test_simultaneous();
      test_reset_mid_fill();
      test_illegal_beats();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
